// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding request, one-entry skid buffer, redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky MisalignErr that halts fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemRData,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7_5
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        MisalignErr
`endif
);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_FULL,
    ST_DROP
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, pc_n;
  logic [31:0] hold_addr, hold_n;
  logic        live;
  logic        valid_q, v_n;
  logic [31:0] instr_q, i_n;
  logic [31:0] pc_q, p_n;
  logic [31:0] pcp4_q, p4_n;
  logic [31:0] skid_instr, sk_i_n;
  logic [31:0] skid_pc, sk_p_n;
  logic        err;
  logic        fire, redirect, accept;
  logic [31:0] tgt;

  assign fire     = IMemReq & IMemReady;
  assign redirect = PCSrc & valid_q;
  assign accept   = ~valid_q | ~Stall;
  assign tgt      = PCTarget & 32'hFFFF_FFFC;

  // DROP keeps the abandoned request alive until the memory answers it
  assign IMemReq  = live & ((state == ST_DROP) |
                            ((state == ST_REQ) & ~err));
  assign IMemAddr = (state == ST_DROP) ? hold_addr : fetch_pc;

  assign InstrValid = valid_q;
  assign Instr      = valid_q ? instr_q : NOP_INSTR;
  assign PC         = pc_q;
  assign PCPlus4    = pcp4_q;
  assign op         = Instr[6:0];
  assign funct3     = Instr[14:12];
  assign funct7_5   = Instr[30];

  always_comb begin
    state_n = state;
    pc_n    = fetch_pc;
    hold_n  = hold_addr;
    v_n     = valid_q & Stall;
    i_n     = instr_q;
    p_n     = pc_q;
    p4_n    = pcp4_q;
    sk_i_n  = skid_instr;
    sk_p_n  = skid_pc;
    if (redirect) begin
      v_n     = 1'b0;
      pc_n    = tgt;
      hold_n  = IMemAddr;
      state_n = (IMemReq && !IMemReady) ? ST_DROP : ST_REQ;
    end else begin
      unique case (state)
        ST_REQ: begin
          if (fire) begin
            pc_n = fetch_pc + 32'd4;
            if (accept) begin
              v_n  = 1'b1;
              i_n  = IMemRData;
              p_n  = fetch_pc;
              p4_n = fetch_pc + 32'd4;
            end else begin
              sk_i_n  = IMemRData;
              sk_p_n  = fetch_pc;
              state_n = ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (!Stall) begin
            v_n     = 1'b1;
            i_n     = skid_instr;
            p_n     = skid_pc;
            p4_n    = skid_pc + 32'd4;
            state_n = ST_REQ;
          end
        end
        ST_DROP: begin
          if (IMemReady) state_n = ST_REQ;
        end
        default: state_n = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_REQ;
      fetch_pc   <= RESET_PC;
      hold_addr  <= RESET_PC;
      live       <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= 32'd0;
      pcp4_q     <= 32'd0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= 32'd0;
    end else begin
      state      <= state_n;
      fetch_pc   <= pc_n;
      hold_addr  <= hold_n;
      live       <= 1'b1;
      valid_q    <= v_n;
      instr_q    <= i_n;
      pc_q       <= p_n;
      pcp4_q     <= p4_n;
      skid_instr <= sk_i_n;
      skid_pc    <= sk_p_n;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else if (redirect && (PCTarget[1:0] != 2'b00)) err <= 1'b1;
  end
  assign MisalignErr = err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a program-order PC model.
// Build with FETCH_MISALIGN_CHECK_EN defined to cover the misalignment trap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemRData;
  logic        Stall;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        InstrValid;
  logic [31:0] Instr, PC, PCPlus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        MisalignErr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemRData(IMemRData),
    .Stall(Stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .InstrValid(InstrValid), .Instr(Instr),
    .PC(PC), .PCPlus4(PCPlus4),
    .op(op), .funct3(funct3), .funct7_5(funct7_5)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .MisalignErr(MisalignErr)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign IMemRData = IMemReady ? mem_word(IMemAddr) : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic stl,
                       input logic src, input logic [31:0] t);
    IMemReady = rdy;
    Stall     = stl;
    PCSrc     = src;
    PCTarget  = t;
  endtask

  logic [31:0] exp_pc, w, hold_i, hold_p, pend_addr;
  logic        hold_pend, req_pend;
  int          consumed;

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_req", IMemReq, 0);
    chk("rst_valid", InstrValid, 0);
    chk("rst_instr", Instr, 32'h13);
    chk("rst_pc", PC, 0);
    chk("rst_pcp4", PCPlus4, 0);
    chk("rst_addr", IMemAddr, 0);

    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("c1_req", IMemReq, 1);
    chk("c1_addr", IMemAddr, 32'h0);
    chk("c1_valid", InstrValid, 0);
    tick();
    chk("c2_valid", InstrValid, 1);
    chk("c2_instr", Instr, 32'h0050_0093);
    chk("c2_pc", PC, 32'h0);
    chk("c2_op", op, 7'b0010011);
    chk("c2_f3", funct3, 3'b000);
    chk("c2_addr", IMemAddr, 32'h4);
    tick();
    chk("c3_instr", Instr, 32'h00A0_0113);
    chk("c3_pc", PC, 32'h4);
    chk("c3_pcp4", PCPlus4, 32'h8);
    chk("c3_addr", IMemAddr, 32'h8);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_addr", IMemAddr, 32'h8);
      chk("wait_req", IMemReq, 1);
      chk("wait_valid", InstrValid, 0);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("w_pc", PC, 32'h8);
    chk("w_instr", Instr, mem_word(32'h8));

    drive(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_valid", InstrValid, 1);
      chk("stall_instr", Instr, mem_word(32'h8));
      chk("stall_pc", PC, 32'h8);
      chk("stall_req", IMemReq, 0);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("skid_valid", InstrValid, 1);
    chk("skid_pc", PC, 32'hC);
    chk("skid_instr", Instr, mem_word(32'hC));
    chk("skid_addr", IMemAddr, 32'h10);
    chk("skid_req", IMemReq, 1);

    drive(1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    chk("drop_valid", InstrValid, 0);
    chk("drop_addr", IMemAddr, 32'h10);
    chk("drop_req", IMemReq, 1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drop2_addr", IMemAddr, 32'h10);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drop3_valid", InstrValid, 0);
    chk("drop3_addr", IMemAddr, 32'h100);
    tick();
    chk("tgt_valid", InstrValid, 1);
    chk("tgt_pc", PC, 32'h100);
    chk("tgt_instr", Instr, mem_word(32'h100));

    drive(1'b1, 1'b1, 1'b1, 32'h200);
    tick();
    chk("flush_valid", InstrValid, 0);
    chk("flush_instr", Instr, 32'h13);
    chk("flush_addr", IMemAddr, 32'h200);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("flush_pc", PC, 32'h200);

    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_pc", PC, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PCPlus4, 32'h0);
    chk("wrap_addr", IMemAddr, 32'h0);

    drive(1'b1, 1'b0, 1'b1, 32'h303);
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("mis_err", MisalignErr, 1);
      chk("mis_req", IMemReq, 0);
      chk("mis_valid", InstrValid, 0);
      tick();
    end
`else
    chk("mask_addr", IMemAddr, 32'h300);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mask_req", IMemReq, 1);
`endif

    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mid_rst_req", IMemReq, 0);
    chk("mid_rst_valid", InstrValid, 0);
    tick();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mid_rst_err", MisalignErr, 0);
`endif
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0);

    exp_pc    = 32'h0;
    hold_pend = 1'b0;
    req_pend  = 1'b0;
    hold_i    = 32'h0;
    hold_p    = 32'h0;
    pend_addr = 32'h0;
    consumed  = 0;
    tick();
    for (int n = 0; n < 4000; n++) begin
      if (hold_pend) begin
        chk("r_hold_valid", InstrValid, 1);
        chk("r_hold_instr", Instr, hold_i);
        chk("r_hold_pc", PC, hold_p);
      end
      if (req_pend) begin
        chk("r_req_stable", IMemReq, 1);
        chk("r_addr_stable", IMemAddr, pend_addr);
      end
      IMemReady = ($urandom_range(3) != 0);
      Stall     = ($urandom_range(3) == 0);
      PCSrc     = ($urandom_range(9) == 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      PCTarget  = $urandom & 32'hFFFF_FFFC;
`else
      PCTarget  = $urandom;
`endif
      if (!InstrValid) chk("r_nop", Instr, 32'h13);
      if (InstrValid && PCSrc) begin
        exp_pc = PCTarget & 32'hFFFF_FFFC;
      end else if (InstrValid && !Stall) begin
        w = mem_word(exp_pc);
        chk("r_pc", PC, exp_pc);
        chk("r_instr", Instr, w);
        chk("r_pcp4", PCPlus4, exp_pc + 32'd4);
        chk("r_op", op, w[6:0]);
        chk("r_f3", funct3, w[14:12]);
        chk("r_f75", funct7_5, w[30]);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      hold_pend = InstrValid && Stall && !PCSrc;
      hold_i    = Instr;
      hold_p    = PC;
      req_pend  = IMemReq && !IMemReady;
      pend_addr = IMemAddr;
      tick();
    end
    chk("r_progress", (consumed >= 500) ? 32'd1 : 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), instruction presented while no valid instruction is held.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 IMemReq  output  1  instruction-memory request.
REQ-006 IMemAddr  output  32  word-aligned fetch address.
REQ-007 IMemReady  input  1  memory response valid; IMemRData valid this cycle.
REQ-008 IMemRData  input  32  fetched instruction word.
REQ-009 Stall  input  1  downstream cannot accept a new instruction this cycle.
REQ-010 PCSrc  input  1  redirect from control unit; honoured only while InstrValid=1.
REQ-011 PCTarget  input  32  redirect address.
REQ-012 InstrValid  output  1  Instr/PC outputs hold a live instruction.
REQ-013 Instr, PC, PCPlus4  output  32 each  held instruction, its address, address+4.
REQ-014 op [7], funct3 [3], funct7_5 [1]  output  decode fields Instr[6:0], Instr[14:12], Instr[30], driving the control unit.

Function
REQ-015 States SHALL be REQ (request outstanding or issuable), FULL (response parked in one-entry skid buffer), DROP (discard in-flight response after redirect).
REQ-016 In REQ, IMemReq SHALL be 1 and IMemAddr SHALL equal the fetch PC; once asserted, IMemReq and IMemAddr SHALL stay stable until IMemReady=1.
REQ-017 REQ, IMemReady=1, (InstrValid=0 or Stall=0): output register loads IMemRData, PC, PC+4; InstrValid=1 next cycle; fetch PC += 4; stay REQ (zero-bubble back-to-back fetch at 1 instr/cycle with IMemReady tied high).
REQ-018 REQ, IMemReady=1, InstrValid=1, Stall=1: response stored in skid buffer, fetch PC += 4, go FULL; IMemReq=0 in FULL.
REQ-019 FULL, Stall=0: skid moves to output register, return to REQ; Stall=1: hold.
REQ-020 InstrValid=1, Stall=0, no new response: InstrValid SHALL clear next cycle (instruction consumed).
REQ-021 InstrValid=1, Stall=1: Instr, PC, PCPlus4, InstrValid SHALL hold unchanged.
REQ-022 Redirect (PCSrc=1 and InstrValid=1) SHALL take priority over Stall: fetch PC<=PCTarget, InstrValid<=0, skid cleared, next cycle IMemAddr=PCTarget.
REQ-023 Redirect while a request is outstanding and IMemReady=0: go DROP; hold request until IMemReady=1, discard that data, then REQ at PCTarget.
REQ-024 Redirect in the same cycle IMemReady=1: that response SHALL be discarded.
REQ-025 InstrValid=0: Instr SHALL equal NOP_INSTR and op/funct3/funct7_5 SHALL decode from it (op=0010011, funct3=000, funct7_5=0).
REQ-026 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-027 rst=1 SHALL immediately force: fetch PC=RESET_PC, state REQ, IMemReq=0, InstrValid=0, Instr=NOP_INSTR, PC=0, PCPlus4=0, skid empty.
REQ-028 IMemReq SHALL first assert in the first cycle after rst deasserts, with IMemAddr=RESET_PC.
REQ-029 Reset mid-request SHALL abandon the request; any later IMemReady for it before a new request SHALL be ignored.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN defined: output MisalignErr (1 bit, sticky until reset); redirect with PCTarget[1:0]!=0 SHALL set MisalignErr, flush as REQ-022, and stop fetching (IMemReq=0) until reset.
REQ-031 Macro undefined: no MisalignErr port; PCTarget[1:0] SHALL be ignored (forced 00).

Verification
REQ-032 Reset release, IMemReady=1 always, words 0x00500093,0x00A00113 -> IMemAddr 0,4,8 on consecutive cycles; InstrValid=1 from cycle 2; op=0010011, funct3=000.
REQ-033 IMemReady low 3 cycles after request at 0x8 -> IMemAddr stays 0x8, IMemReq stays 1, InstrValid=0 during wait.
REQ-034 Stall=1 for 2 cycles with response arriving -> output holds previous Instr; state FULL, IMemReq=0; Stall=0 -> parked instruction presented, PC=+4 next.
REQ-035 PCSrc=1, PCTarget=0x100 while request to 0x10 pending, IMemReady delayed 2 cycles -> returned data dropped; next IMemAddr=0x100; no instruction from 0x10 ever InstrValid.
REQ-036 PCSrc=1 with Stall=1 -> flush wins; InstrValid=0 next cycle, Instr=0x00000013.
REQ-037 With FETCH_MISALIGN_CHECK_EN, PCTarget=0x102 -> MisalignErr=1, IMemReq=0 until rst.
